// File: rtl/led_pattern_gen_pkg.sv
// Shared mode codes and widths for the LED pattern generator.
package led_pattern_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_CHASE  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd4;
  localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_DIM    = 3'd6;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the indicator control logic (master) and the
// pattern generator (slave).
interface led_pattern_gen_if #(
  parameter int N_LED    = 4,
  parameter int PWM_BITS = 4
);

  logic [led_pattern_pkg::MODE_W-1:0] mode_in;
  logic                               mode_load;
  logic                               pause;
  logic [PWM_BITS-1:0]                duty;
  logic [N_LED-1:0]                   led;
  logic                               tick;
  logic [led_pattern_pkg::MODE_W-1:0] mode_cur;

  modport master (
    output mode_in, mode_load, pause, duty,
    input  led, tick, mode_cur
  );

  modport slave (
    input  mode_in, mode_load, pause, duty,
    output led, tick, mode_cur
  );

endinterface

// File: rtl/led_pattern_gen_prescaler.sv
// Divide counter 0..TICK_DIV-1; tick_next flags the edge that wraps it.
// clear wins over enable and suppresses a coincident wrap.
module led_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clck,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_next
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap    = enable && (r_cnt == LAST);
  assign tick_next = w_wrap && !clear;

  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaled pattern tick, seven modes,
// pause and restart on mode_load.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int PWM_BITS = 4
) (
  input  logic         clck,
  input  logic         reset,
  led_pattern_gen_if.slave bus
);

  logic [MODE_W-1:0]   r_mode;
  logic [N_LED-1:0]    r_led;
  logic                r_dir_up;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_tick;

  logic                w_tick_next;
  logic                w_lit;
  logic [N_LED-1:0]    w_led_nxt;
  logic                w_dir_nxt;

  led_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clck      (clck),
    .reset     (reset),
    .clear     (bus.mode_load),
    .enable    (!bus.pause),
    .tick_next (w_tick_next)
  );

  function automatic logic [N_LED-1:0] init_pattern(input logic [MODE_W-1:0] m);
    case (m)
      MODE_ON:                 init_pattern = {N_LED{1'b1}};
      MODE_CHASE, MODE_BOUNCE: init_pattern = N_LED'(1);
      default:                 init_pattern = '0;
    endcase
  endfunction

  assign w_lit = (r_pwm < bus.duty);

  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir_up;
    if (bus.mode_load) begin
      w_led_nxt = init_pattern(bus.mode_in);
      w_dir_nxt = 1'b1;
    end else if (!bus.pause) begin
      if (r_mode == MODE_DIM) begin
        w_led_nxt = {N_LED{w_lit}};
      end else if (w_tick_next) begin
        case (r_mode)
          MODE_BLINK: w_led_nxt = ~r_led;
          // Shift-based rotate also degenerates to a hold when N_LED is 1.
          MODE_CHASE: w_led_nxt = (r_led << 1) | (r_led >> (N_LED - 1));
          MODE_BOUNCE: begin
            if (N_LED == 1) begin
              w_led_nxt = r_led;
            end else if (r_dir_up) begin
              if (r_led[N_LED-1]) begin
                w_led_nxt = r_led >> 1;
                w_dir_nxt = 1'b0;
              end else begin
                w_led_nxt = r_led << 1;
              end
            end else begin
              if (r_led[0]) begin
                w_led_nxt = r_led << 1;
                w_dir_nxt = 1'b1;
              end else begin
                w_led_nxt = r_led >> 1;
              end
            end
          end
          MODE_COUNT: w_led_nxt = r_led + N_LED'(1);
          default:    w_led_nxt = r_led;
        endcase
      end
    end
  end

  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_OFF;
      r_led    <= '0;
      r_dir_up <= 1'b1;
      r_pwm    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_led    <= w_led_nxt;
      r_dir_up <= w_dir_nxt;
      r_tick   <= w_tick_next;
      if (bus.mode_load) begin
        r_mode <= bus.mode_in;
        r_pwm  <= '0;
      end else if (!bus.pause) begin
        r_pwm <= r_pwm + PWM_BITS'(1);
      end
    end
  end

  assign bus.led      = r_led;
  assign bus.tick     = r_tick;
  assign bus.mode_cur = r_mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus queues expected (led, cycle) per tick; a monitor
// pops and compares on each tick pulse.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int PB = 4;

  typedef struct {
    logic [N-1:0] led;
    int           at;
  } exp_t;

  logic clck  = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  logic [N-1:0] chase_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                   4'b0010, 4'b0001, 4'b0010};

  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  led_pattern_gen_if #(.N_LED(N), .PWM_BITS(PB)) bus();

  led_pattern_gen #(.N_LED(N), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
    .clck  (clck),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick pulse while armed must match the head of the scoreboard.
  always @(negedge clck) begin
    if (mon_en && bus.tick === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: led %0h at cycle %0d with empty scoreboard", bus.led, cyc);
      end else begin
        e = sb.pop_front();
        chk("tick_led", 32'(bus.led), 32'(e.led));
        chk("tick_cycle", cyc, e.at);
      end
    end
  end

  task automatic load(input logic [MODE_W-1:0] m, output int k);
    @(negedge clck);
    bus.mode_in   = m;
    bus.mode_load = 1'b1;
    @(negedge clck);
    bus.mode_load = 1'b0;
    bus.mode_in   = 3'd7;
    k = cyc;
  endtask

  task automatic push(input logic [N-1:0] led, input int at);
    exp_t e;
    e.led = led;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic drain(input int n);
    repeat (TD * n + 1) @(negedge clck);
    chk("sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int lit;
    int odd;
    int frozen;

    bus.mode_in   = '0;
    bus.mode_load = 1'b0;
    bus.pause     = 1'b0;
    bus.duty      = '0;

    repeat (3) @(negedge clck);
    chk("reset_led", 32'(bus.led), 0);
    chk("reset_mode", 32'(bus.mode_cur), 0);
    chk("reset_tick", 32'(bus.tick), 0);
    reset = 1'b0;
    @(negedge clck);

    load(MODE_ON, k);
    chk("on_led", 32'(bus.led), 32'hF);
    chk("on_mode", 32'(bus.mode_cur), 1);
    load(3'd7, k);
    chk("rsvd_led", 32'(bus.led), 0);
    chk("rsvd_mode", 32'(bus.mode_cur), 7);

    load(MODE_CHASE, k);
    chk("chase_init", 32'(bus.led), 32'h1);
    chk("chase_mode", 32'(bus.mode_cur), 3);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) push(chase_exp[i], k + TD * (i + 1));
    drain(4);

    load(MODE_BOUNCE, k);
    chk("bounce_init", 32'(bus.led), 32'h1);
    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) push(bounce_exp[i], k + TD * (i + 1));
    drain(7);

    load(MODE_COUNT, k);
    chk("count_init", 32'(bus.led), 0);
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) push(N'(i + 1), k + TD * (i + 1));
    drain(18);
    chk("count_before_reload", 32'(bus.led), 32'h2);
    load(MODE_COUNT, k);
    chk("count_reload", 32'(bus.led), 0);
    mon_en = 1'b1;
    push(4'b0001, k + TD);
    push(4'b0010, k + 2 * TD);
    drain(2);

    bus.duty = 4'd4;
    load(MODE_DIM, k);
    lit = 0;
    odd = 0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clck);
      if (j == 1) chk("dim_first_on", 32'(bus.led), 32'hF);
      if (j == 5) chk("dim_first_off", 32'(bus.led), 0);
      if (bus.led === 4'hF) lit++;
      else if (bus.led !== 4'h0) odd++;
    end
    chk("dim4_lit", lit, 8);
    bus.duty = 4'd15;
    lit = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clck);
      if (bus.led === 4'hF) lit++;
      else if (bus.led !== 4'h0) odd++;
    end
    chk("dim15_lit", lit, 15);
    bus.duty = 4'd0;
    lit = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clck);
      if (bus.led !== 4'h0) lit++;
    end
    chk("dim0_lit", lit, 0);
    chk("dim_partial", odd, 0);

    load(MODE_BLINK, k);
    chk("blink_init", 32'(bus.led), 0);
    mon_en = 1'b1;
    push(4'b1111, k + 14);
    push(4'b0000, k + 18);
    repeat (2) @(negedge clck);
    bus.pause = 1'b1;
    frozen = 0;
    repeat (10) begin
      @(negedge clck);
      if (bus.tick !== 1'b0 || bus.led !== 4'h0) frozen++;
    end
    bus.pause = 1'b0;
    chk("pause_frozen", frozen, 0);
    repeat (7) @(negedge clck);
    chk("pause_sb_drained", sb.size(), 0);
    mon_en = 1'b0;
    sb.delete();

    @(negedge clck);
    bus.pause = 1'b1;
    load(MODE_CHASE, k);
    chk("pause_load_led", 32'(bus.led), 32'h1);
    chk("pause_load_mode", 32'(bus.mode_cur), 3);
    repeat (8) @(negedge clck);
    chk("pause_load_hold", 32'(bus.led), 32'h1);
    bus.pause = 1'b0;

    load(MODE_CHASE, k);
    repeat (2 * TD) @(negedge clck);
    chk("pre_reset_led", 32'(bus.led), 32'h4);
    chk("pre_reset_tick", 32'(bus.tick), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_led", 32'(bus.led), 0);
    chk("async_reset_mode", 32'(bus.mode_cur), 0);
    chk("async_reset_tick", 32'(bus.tick), 0);
    @(negedge clck);
    reset = 1'b0;
    repeat (2 * TD) @(negedge clck);
    chk("post_reset_off", 32'(bus.led), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
